// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU data-port decoder that maps the top 8 words to board I/O and forwards the rest to RAM.
// Define MMIO_TIMER_EN to build the free-running 9-bit cycle timer at offset 4.
module mmio_bridge #(
    parameter int                g_ADDR      = 11,
    parameter int                g_WIDTH     = 9,
    parameter logic [g_ADDR-1:0] g_IO_BASE   = 11'h7F8,
    parameter int                g_DEBOUNCE  = 50000,
    parameter int                g_DB_BITS   = 16,
    parameter logic [7:0]        g_LED_RESET = 8'b10011001
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ram_en,
    input  logic               i_ram_we,
    input  logic               i_ram_re,
    input  logic [g_ADDR-1:0]  i_ram_addr,
    input  logic [g_WIDTH-1:0] i_ram_data,
    output logic [g_WIDTH-1:0] o_ram_data,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic               o_mem_re,
    output logic [g_ADDR-1:0]  o_mem_addr,
    output logic [g_WIDTH-1:0] o_mem_data,
    input  logic [g_WIDTH-1:0] i_mem_data,
    input  logic [7:0]         i_sw,
    input  logic [4:0]         i_btn,
    output logic [7:0]         o_led
);
    logic hit, rd, wr;
    logic [2:0] off;
    logic [7:0] sw_s1_q, sw_s2_q;
    logic [4:0] btn_s1_q, btn_s2_q, btn_db_q, btn_db_d, evt_q, evt_d;
    logic [g_DB_BITS-1:0] cnt_q [5];
    logic [g_DB_BITS-1:0] cnt_d [5];
    logic [g_WIDTH-1:0] led_q, led_d, rdata_q, rdata_d, io_rdata;
    logic sel_q, sel_d;

    assign hit = i_ram_addr[g_ADDR-1:3] == g_IO_BASE[g_ADDR-1:3];
    assign off = i_ram_addr[2:0];
    assign rd  = i_ram_en & i_ram_re;
    assign wr  = i_ram_en & i_ram_we;

    assign o_mem_en   = i_ram_en & ~hit;
    assign o_mem_we   = i_ram_we & ~hit;
    assign o_mem_re   = i_ram_re & ~hit;
    assign o_mem_addr = i_ram_addr;
    assign o_mem_data = i_ram_data;

`ifdef MMIO_TIMER_EN
    logic [8:0] tmr_q, tmr_d;
    assign tmr_d = (wr && hit && off == 3'd4) ? i_ram_data[8:0] : tmr_q + 9'd1;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) tmr_q <= '0;
        else       tmr_q <= tmr_d;
`endif

    always_comb begin
        btn_db_d = btn_db_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (btn_s2_q[i] != btn_db_q[i]) begin
                if (cnt_q[i] == g_DB_BITS'(g_DEBOUNCE - 1)) btn_db_d[i] = ~btn_db_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            3'd0: io_rdata = led_q;
            3'd1: io_rdata = g_WIDTH'(sw_s2_q);
            3'd2: io_rdata = g_WIDTH'(btn_db_q);
            3'd3: io_rdata = g_WIDTH'(evt_q);
`ifdef MMIO_TIMER_EN
            3'd4: io_rdata = g_WIDTH'(tmr_q);
`endif
            default: io_rdata = '0;
        endcase
    end

    // A fresh rising edge re-sets its flag even when the same cycle clears it.
    assign evt_d   = (evt_q & ~((rd && hit && off == 3'd3) ? evt_q : 5'b0)) | (btn_db_d & ~btn_db_q);
    assign led_d   = (wr && hit && off == 3'd0) ? i_ram_data : led_q;
    assign rdata_d = (rd && hit) ? io_rdata : rdata_q;
    assign sel_d   = rd ? hit : sel_q;

    assign o_ram_data = sel_q ? rdata_q : i_mem_data;
    assign o_led      = led_q[7:0];

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            btn_db_q <= '0;
            evt_q    <= '0;
            led_q    <= g_WIDTH'(g_LED_RESET);
            rdata_q  <= '0;
            sel_q    <= 1'b0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sw_s1_q  <= i_sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= i_btn;
            btn_s2_q <= btn_s1_q;
            btn_db_q <= btn_db_d;
            evt_q    <= evt_d;
            led_q    <= led_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed stimulus against a behavioural register-map model plus a registered RAM.
module tb_mmio_bridge;
    logic        clk = 1'b0, rst = 1'b1;
    logic        en, we, re;
    logic [10:0] addr;
    logic [8:0]  wdata, o_ram_data, i_mem_data, mem_data;
    logic        mem_en, mem_we, mem_re;
    logic [10:0] mem_addr;
    logic [7:0]  sw, led;
    logic [4:0]  btn;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.g_ADDR(11), .g_WIDTH(9), .g_IO_BASE(11'h7F8), .g_DEBOUNCE(4),
                  .g_DB_BITS(16), .g_LED_RESET(8'h99)) dut (
        .i_clk(clk), .i_rst(rst), .i_ram_en(en), .i_ram_we(we), .i_ram_re(re),
        .i_ram_addr(addr), .i_ram_data(wdata), .o_ram_data(o_ram_data),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_re(mem_re),
        .o_mem_addr(mem_addr), .o_mem_data(mem_data), .i_mem_data(i_mem_data),
        .i_sw(sw), .i_btn(btn), .o_led(led));

    // RAM with a registered read port, as seen by the bridge
    logic [8:0] ram [0:2047];
    logic [8:0] ram_q;
    assign i_mem_data = ram_q;
    always @(posedge clk or posedge rst)
        if (rst) ram_q <= '0;
        else begin
            if (mem_en && mem_we) ram[mem_addr] <= mem_data;
            if (mem_en && mem_re) ram_q <= ram[mem_addr];
        end

    // Behavioural model of what the CPU must observe
    logic [8:0] m_led, m_rd;
    logic [8:0] m_ram [0:2047];
    logic [7:0] sw1, sw2;
    logic [4:0] m_btn = '0, m_evt = '0;
`ifdef MMIO_TIMER_EN
    logic [8:0] m_tmr;
`endif

    function automatic logic [8:0] io_val(input logic [2:0] o);
        case (o)
            3'd0: return m_led;
            3'd1: return {1'b0, sw2};
            3'd2: return {4'b0, m_btn};
            3'd3: return {4'b0, m_evt};
`ifdef MMIO_TIMER_EN
            3'd4: return m_tmr;
`endif
            default: return 9'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m_led <= 9'h099;
            m_rd  <= '0;
            sw1   <= '0;
            sw2   <= '0;
`ifdef MMIO_TIMER_EN
            m_tmr <= '0;
`endif
        end else begin
            sw1 <= sw;
            sw2 <= sw1;
`ifdef MMIO_TIMER_EN
            m_tmr <= (en && we && addr == 11'h7FC) ? wdata : m_tmr + 9'd1;
`endif
            if (en && we && addr == 11'h7F8) m_led <= wdata;
            if (en && we && addr < 11'h7F8) m_ram[addr] <= wdata;
            if (en && re) m_rd <= (addr >= 11'h7F8) ? io_val(addr[2:0]) : m_ram[addr];
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            chk("fwd_strobes", {mem_en, mem_we, mem_re},
                {en && addr < 11'h7F8, we && addr < 11'h7F8, re && addr < 11'h7F8});
            chk("fwd_addr_data", {mem_addr, mem_data}, {addr, wdata});
            chk("led", led, m_led[7:0]);
            chk("rdata", o_ram_data, m_rd);
        end

    task automatic put(input logic [10:0] a, input logic [8:0] d, input logic w, input logic r);
        en = 1'b1; we = w; re = r; addr = a; wdata = d;
    endtask
    task automatic go();
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0; re = 1'b0;
    endtask
    task automatic wr(input logic [10:0] a, input logic [8:0] d);
        put(a, d, 1'b1, 1'b0); go();
    endtask
    task automatic rd(input logic [10:0] a);
        put(a, 9'd0, 1'b0, 1'b1); go();
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    localparam logic [8:0] T0 =
`ifdef MMIO_TIMER_EN
        9'h1FE;
`else
        9'h000;
`endif
    localparam logic [8:0] T1 =
`ifdef MMIO_TIMER_EN
        9'h1FF;
`else
        9'h000;
`endif

    initial begin
        en = 0; we = 0; re = 0; addr = '0; wdata = '0; sw = '0; btn = '0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_led", led, 8'h99);
        chk("rst_rdata", o_ram_data, 9'h000);
        rd(11'h7FB);
        chk("rst_evt", o_ram_data, 9'h000);
        rd(11'h7F8);
        chk("rst_led_reg", o_ram_data, 9'h099);

        put(11'h7F8, 9'h1A5, 1'b1, 1'b0); #1;
        chk("io_wr_no_ram", mem_en, 1'b0);
        go();
        chk("led_a5", led, 8'hA5);
        rd(11'h7F8);
        chk("led_rd", o_ram_data, 9'h1A5);

        put(11'h010, 9'h055, 1'b1, 1'b0); #1;
        chk("ram_wr_fwd", {mem_en, mem_we, mem_addr, mem_data}, {1'b1, 1'b1, 11'h010, 9'h055});
        go();
        rd(11'h010);
        chk("ram_rd", o_ram_data, 9'h055);
        idle(2);
        chk("ram_rd_hold", o_ram_data, 9'h055);

        sw = 8'hC3;
        idle(3);
        rd(11'h7F9);
        chk("sw_rd", o_ram_data, 9'h0C3);
        btn[2] = 1'b1; idle(2); btn[2] = 1'b0; idle(6);
        rd(11'h7FA);
        chk("btn_short", o_ram_data, 9'h000);

        btn[2] = 1'b1; idle(10);
        m_btn = 5'h04; m_evt = 5'h04;
        rd(11'h7FA);
        chk("btn_long", o_ram_data, 9'h004);
        rd(11'h7FB);
        chk("evt_first", o_ram_data, 9'h004);
        m_evt = 5'h00;
        rd(11'h7FB);
        chk("evt_cleared", o_ram_data, 9'h000);
        btn[2] = 1'b0; idle(12);
        m_btn = 5'h00;
        rd(11'h7FA);
        chk("btn_release", o_ram_data, 9'h000);
        rd(11'h7FB);
        chk("evt_no_fall", o_ram_data, 9'h000);
        // press so that the debounced edge lands on the clearing read
        btn[2] = 1'b1; idle(5);
        rd(11'h7FB);
        chk("evt_coincident", o_ram_data, 9'h000);
        m_btn = 5'h04; m_evt = 5'h04;
        rd(11'h7FB);
        chk("evt_set_wins", o_ram_data, 9'h004);
        m_evt = 5'h00;
        rd(11'h7FB);
        chk("evt_after", o_ram_data, 9'h000);

        wr(11'h7FF, 9'h1FF);
        rd(11'h7FF);
        chk("unused_7ff", o_ram_data, 9'h000);
        rd(11'h7FD);
        chk("unused_7fd", o_ram_data, 9'h000);
        chk("led_kept", led, 8'hA5);

        put(11'h7F8, 9'h033, 1'b1, 1'b1); go();
        chk("rd_wr_pre", o_ram_data, 9'h1A5);
        chk("rd_wr_led", led, 8'h33);

        wr(11'h7FC, 9'h1FE);
        rd(11'h7FC);
        chk("tmr_0", o_ram_data, T0);
        wr(11'h7FC, 9'h1FE); idle(1);
        rd(11'h7FC);
        chk("tmr_1", o_ram_data, T1);
        wr(11'h7FC, 9'h1FE); idle(2);
        rd(11'h7FC);
        chk("tmr_wrap", o_ram_data, 9'h000);

        put(11'h7F8, 9'h0FF, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_led", led, 8'h99);
        chk("arst_rdata", o_ram_data, 9'h000);
        @(posedge clk); #1;
        en = 0; we = 0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_led", led, 8'h99);
        rd(11'h7F8);
        chk("post_rst_led_rd", o_ram_data, 9'h099);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
